// File: rtl/pooling_2d_stream.sv
// pooling_2d_stream: streaming non-overlapping 2D pooling (max/min/shifted-sum avg).
// Pixels arrive in raster order on in_*; one pooled result per KxK window leaves on out_*.
// Ports: ACLK/ARESET clock and async active-high reset; cfg_* runtime configuration
// latched on an accepted cfg_start; busy/done/err status; in_* pixel stream (valid/ready);
// out_* result stream (valid/ready).
module pooling_2d_stream #(
  parameter int DATA_WIDTH      = 32,
  parameter int KERNEL_MAX_SIZE = 7,
  parameter int WIDTH_MAX       = 64,
  parameter int HEIGHT_MAX      = 64,
  parameter int ACC_WIDTH       = DATA_WIDTH + 6
) (
  input  logic                                  ACLK,
  input  logic                                  ARESET,
  input  logic                                  cfg_start,
  input  logic [2:0]                            cfg_kernel,
  input  logic [1:0]                            cfg_mode,
  input  logic [5:0]                            cfg_shift,
  input  logic [$clog2(WIDTH_MAX+1)-1:0]        cfg_width,
  input  logic [$clog2(HEIGHT_MAX+1)-1:0]       cfg_height,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int WW = $clog2(WIDTH_MAX + 1);
  localparam int HW = $clog2(HEIGHT_MAX + 1);
  localparam int IW = $clog2(WIDTH_MAX);

  localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  typedef enum logic [1:0] {MODE_MAX, MODE_MIN, MODE_AVG} mode_t;

  state_t        state;
  mode_t         mode_r;
  logic [2:0]    k_r;
  logic [5:0]    shift_r;
  logic [WW-1:0] w_r, ow_r, col, oc;
  logic [HW-1:0] h_r, oh_r, row, orow;
  logic [2:0]    kc, kr;

  logic signed [ACC_WIDTH-1:0] acc [WIDTH_MAX];

  logic [WW-1:0] k_w;
  logic [HW-1:0] k_h;
  logic          cfg_bad;
  logic          accept, kc_last, kr_last, row_end, last_pix, discard, win_done;
  logic [IW-1:0] idx;
  logic signed [ACC_WIDTH-1:0] pix_ext, acc_rd, comb, shifted;
  logic [DATA_WIDTH-1:0] res;

  assign k_w = WW'(cfg_kernel);
  assign k_h = HW'(cfg_kernel);

  always_comb begin
    cfg_bad = (cfg_kernel == '0) || (int'(cfg_kernel) > KERNEL_MAX_SIZE) ||
              (cfg_mode == 2'd3) ||
              (cfg_width == '0) || (int'(cfg_width) > WIDTH_MAX) ||
              (cfg_height == '0) || (int'(cfg_height) > HEIGHT_MAX) ||
              (cfg_width < k_w) || (cfg_height < k_h);
  end

  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign kc_last  = (kc == k_r - 3'd1);
  assign kr_last  = (kr == k_r - 3'd1);
  assign row_end  = (col == w_r - WW'(1));
  assign last_pix = row_end && (row == h_r - HW'(1));
  // Right and bottom remainders fall outside every complete window.
  assign discard  = (oc >= ow_r) || (orow >= oh_r);
  assign win_done = kc_last && kr_last && !discard;
  assign idx      = oc[IW-1:0];
  assign pix_ext  = ACC_WIDTH'($signed(in_data));
  assign acc_rd   = acc[idx];

  always_comb begin
    if (kr == '0 && kc == '0) begin
      comb = pix_ext;
    end else begin
      case (mode_r)
        MODE_MAX: comb = (pix_ext > acc_rd) ? pix_ext : acc_rd;
        MODE_MIN: comb = (pix_ext < acc_rd) ? pix_ext : acc_rd;
        default:  comb = acc_rd + pix_ext;
      endcase
    end
  end

  always_comb begin
    shifted = comb >>> shift_r;
    res     = comb[DATA_WIDTH-1:0];
    if (mode_r == MODE_AVG) begin
      if (shifted > SAT_HI)      res = SAT_HI[DATA_WIDTH-1:0];
      else if (shifted < SAT_LO) res = SAT_LO[DATA_WIDTH-1:0];
      else                       res = shifted[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge ACLK) begin
    if (accept && !discard) acc[idx] <= comb;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= S_IDLE;
      mode_r    <= MODE_MAX;
      k_r       <= '0;
      shift_r   <= '0;
      w_r       <= '0;
      h_r       <= '0;
      ow_r      <= '0;
      oh_r      <= '0;
      col       <= '0;
      row       <= '0;
      oc        <= '0;
      orow      <= '0;
      kc        <= '0;
      kr        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            if (cfg_bad) begin
              err <= 1'b1;
            end else begin
              mode_r  <= mode_t'(cfg_mode);
              k_r     <= cfg_kernel;
              shift_r <= cfg_shift;
              w_r     <= cfg_width;
              h_r     <= cfg_height;
              ow_r    <= cfg_width / k_w;
              oh_r    <= cfg_height / k_h;
              col     <= '0;
              row     <= '0;
              oc      <= '0;
              orow    <= '0;
              kc      <= '0;
              kr      <= '0;
              busy    <= 1'b1;
              state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            if (row_end) begin
              col <= '0;
              kc  <= '0;
              oc  <= '0;
              row <= row + HW'(1);
              if (kr_last) begin
                kr   <= '0;
                orow <= orow + HW'(1);
              end else begin
                kr <= kr + 3'd1;
              end
            end else begin
              col <= col + WW'(1);
              if (kc_last) begin
                kc <= '0;
                oc <= oc + WW'(1);
              end else begin
                kc <= kc + 3'd1;
              end
            end
            // Overrides the handshake clear above so a new result follows with no gap.
            if (win_done) begin
              out_valid <= 1'b1;
              out_data  <= res;
            end
            if (last_pix) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!out_valid || out_ready) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pooling_2d_stream.sv
// tb_pooling_2d_stream: directed, table-driven bench for pooling_2d_stream (DATA_WIDTH=8).
module tb_pooling_2d_stream;

  localparam int DW = 8;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          cfg_start = 1'b0;
  logic [2:0]    cfg_kernel = '0;
  logic [1:0]    cfg_mode = '0;
  logic [5:0]    cfg_shift = '0;
  logic [6:0]    cfg_width = '0;
  logic [6:0]    cfg_height = '0;
  logic          busy, done, err;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;

  pooling_2d_stream #(.DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_start(cfg_start), .cfg_kernel(cfg_kernel),
    .cfg_mode(cfg_mode), .cfg_shift(cfg_shift), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .busy(busy), .done(done), .err(err),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    string name;
    int    k, mode, shift, w, h;
    int    kind, base;  // kind 0: base+i, 1: constant base, 2: fixed list
    bit    exp_err;
    int    n_exp, e0, e1, e2, e3;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int got[$];
  int n_acc = 0;
  int n_done = 0;

  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (out_valid && out_ready) got.push_back(int'($signed(out_data)));
      if (in_valid && in_ready) n_acc++;
      if (done) n_done++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input int k, input int mode, input int shift,
                              input int w, input int h, input int kind, input int base,
                              input bit exp_err, input int n_exp, input int e0, input int e1,
                              input int e2, input int e3);
    vec_t v;
    v.name = name; v.k = k; v.mode = mode; v.shift = shift; v.w = w; v.h = h;
    v.kind = kind; v.base = base; v.exp_err = exp_err; v.n_exp = n_exp;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    return v;
  endfunction

  function automatic logic [DW-1:0] pix(input vec_t v, input int i);
    int lst[4] = '{-3, 5, -8, 2};
    case (v.kind)
      0:       return DW'(v.base + i);
      1:       return DW'(v.base);
      default: return DW'(lst[i % 4]);
    endcase
  endfunction

  task automatic start(input int k, input int mode, input int sh, input int w, input int h);
    @(posedge ACLK); #1;
    cfg_kernel = 3'(k); cfg_mode = 2'(mode); cfg_shift = 6'(sh);
    cfg_width = 7'(w); cfg_height = 7'(h); cfg_start = 1'b1;
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, output bit ok);
    int  t;
    bit  hs;
    t = 0; ok = 1'b0;
    in_valid = 1'b1; in_data = d;
    while (t < 200 && !ok) begin
      @(negedge ACLK); hs = in_ready;
      @(posedge ACLK); #1;
      if (hs) ok = 1'b1;
      t++;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_ramp(input string name, input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      send(DW'(i), ok);
      if (!ok) begin
        chk({name, "/in_timeout"}, 0, 1);
        break;
      end
    end
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge ACLK);
      if (done) seen = 1'b1;
    end
    chk({name, "/done_seen"}, int'(seen), 1);
    if (seen) chk({name, "/busy_at_done"}, int'(busy), 0);
    @(posedge ACLK); #1;
    chk({name, "/done_pulse"}, int'(done), 0);
  endtask

  task automatic check_results(input string name, input int n_exp, input int e0, input int e1,
                               input int e2, input int e3);
    int ex[4];
    ex = '{e0, e1, e2, e3};
    chk({name, "/n_out"}, got.size(), n_exp);
    for (int j = 0; j < n_exp && j < got.size(); j++)
      chk($sformatf("%s/out%0d", name, j), got[j], ex[j]);
    chk({name, "/n_done"}, n_done, 1);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    got.delete(); n_acc = 0; n_done = 0;
    start(v.k, v.mode, v.shift, v.w, v.h);
    chk({v.name, "/err"}, int'(err), int'(v.exp_err));
    chk({v.name, "/busy"}, int'(busy), int'(!v.exp_err));
    if (v.exp_err) begin
      @(posedge ACLK); #1;
      chk({v.name, "/err_pulse"}, int'(err), 0);
      chk({v.name, "/busy_after"}, int'(busy), 0);
    end else begin
      for (int i = 0; i < v.w * v.h; i++) begin
        send(pix(v, i), ok);
        if (!ok) begin
          chk({v.name, "/in_timeout"}, 0, 1);
          break;
        end
      end
      wait_done(v.name);
      chk({v.name, "/n_acc"}, n_acc, v.w * v.h);
      check_results(v.name, v.n_exp, v.e0, v.e1, v.e2, v.e3);
    end
  endtask

  initial begin
    vec_t tv[$];
    tv.push_back(mk("max_k2_4x4",   2, 0, 0, 4, 4, 0,   0, 0, 4, 5, 7, 13, 15));
    tv.push_back(mk("avg_k3_7x6",   3, 2, 0, 7, 6, 1,   1, 0, 4, 9, 9, 9, 9));
    tv.push_back(mk("min_k2_2x2",   2, 1, 0, 2, 2, 2,   0, 0, 1, -8, 0, 0, 0));
    tv.push_back(mk("avg_sat_hi",   2, 2, 0, 2, 2, 1, 127, 0, 1, 127, 0, 0, 0));
    tv.push_back(mk("avg_sat_lo",   2, 2, 0, 2, 2, 1, -128, 0, 1, -128, 0, 0, 0));
    tv.push_back(mk("avg_k2_sh2",   2, 2, 2, 4, 2, 0,   0, 0, 2, 2, 4, 0, 0));
    tv.push_back(mk("max_k2_5x3",   2, 0, 0, 5, 3, 0,   0, 0, 2, 6, 8, 0, 0));
    tv.push_back(mk("k1_avg_sh1",   1, 2, 1, 2, 2, 0,   0, 0, 4, 0, 0, 1, 1));
    tv.push_back(mk("k1_max_neg",   1, 0, 0, 3, 1, 0,  -2, 0, 3, -2, -1, 0, 0));
    tv.push_back(mk("max_k7_7x7",   7, 0, 0, 7, 7, 0, -60, 0, 1, -12, 0, 0, 0));
    tv.push_back(mk("bad_k0",       0, 0, 0, 4, 4, 0,   0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk("bad_k8",       8, 0, 0, 4, 4, 0,   0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk("bad_mode3",    2, 3, 0, 4, 4, 0,   0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk("bad_w1_k2",    2, 0, 0, 1, 4, 0,   0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk("bad_h1_k2",    2, 0, 0, 4, 1, 0,   0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk("bad_w0",       1, 0, 0, 0, 4, 0,   0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk("bad_w65",      1, 0, 0, 65, 1, 0,  0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk("bad_h65",      1, 0, 0, 1, 65, 0,  0, 1, 0, 0, 0, 0, 0));

    repeat (3) @(posedge ACLK);
    @(negedge ACLK); ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("reset/busy", int'(busy), 0);
    chk("reset/done", int'(done), 0);
    chk("reset/err", int'(err), 0);
    chk("reset/out_valid", int'(out_valid), 0);
    chk("reset/out_data", int'(out_data), 0);
    chk("reset/in_ready", int'(in_ready), 0);

    foreach (tv[i]) run_vec(tv[i]);

    // cfg_start while running must be ignored.
    begin
      bit ok;
      got.delete(); n_acc = 0; n_done = 0;
      start(2, 0, 0, 4, 4);
      for (int i = 0; i < 16; i++) begin
        if (i == 3) begin cfg_start = 1'b1; cfg_kernel = 3'd0; end
        send(DW'(i), ok);
        if (i == 3) begin
          cfg_start = 1'b0; cfg_kernel = 3'd2;
          chk("midstart/err", int'(err), 0);
          chk("midstart/busy", int'(busy), 1);
        end
        if (!ok) begin chk("midstart/in_timeout", 0, 1); break; end
      end
      wait_done("midstart");
      check_results("midstart", 4, 5, 7, 13, 15);
    end

    // Backpressure: hold out_ready low while the first result is pending.
    got.delete(); n_acc = 0; n_done = 0;
    @(posedge ACLK); #1; out_ready = 1'b0;
    start(2, 0, 0, 4, 2);
    fork
      send_ramp("bp", 8);
      begin
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
          @(negedge ACLK);
          if (out_valid) seen = 1'b1;
        end
        chk("bp/first_seen", int'(seen), 1);
        for (int c = 0; c < 5; c++) begin
          if (c > 0) @(negedge ACLK);
          chk($sformatf("bp/hold_valid%0d", c), int'(out_valid), 1);
          chk($sformatf("bp/hold_data%0d", c), int'($signed(out_data)), 5);
          chk($sformatf("bp/in_ready%0d", c), int'(in_ready), 0);
        end
        @(posedge ACLK); #1; out_ready = 1'b1;
      end
    join
    wait_done("bp");
    chk("bp/n_acc", n_acc, 8);
    check_results("bp", 2, 5, 7, 0, 0);

    // Reset in the middle of a run aborts without a done pulse.
    got.delete(); n_acc = 0; n_done = 0;
    start(2, 0, 0, 4, 4);
    send_ramp("rst_mid", 6);
    chk("rst_mid/pre_valid", int'(out_valid), 1);
    ARESET = 1'b1; #1;
    chk("rst_mid/out_valid", int'(out_valid), 0);
    chk("rst_mid/out_data", int'(out_data), 0);
    chk("rst_mid/busy", int'(busy), 0);
    chk("rst_mid/in_ready", int'(in_ready), 0);
    @(negedge ACLK); ARESET = 1'b0;
    repeat (4) @(posedge ACLK);
    #1;
    chk("rst_mid/no_done", n_done, 0);
    run_vec(tv[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pooling_2d_stream.md
Name: pooling_2d_stream

Overview:
- Parametrised successor to the single-core 2D pooling engine.
- Streaming, non-overlapping (stride = kernel) 2D pooling over one feature map arriving in raster order on a valid/ready stream.
- Runtime-selectable kernel size, map size and mode (max, min, shifted-sum average).
- Sits between the memory-read mover (MR) and memory-write mover (MW) inside the pooling datapath; configured by the CSR block.

Parameters:
- DATA_WIDTH, 32, signed two's-complement pixel width.
- KERNEL_MAX_SIZE, 7, largest legal kernel edge K.
- WIDTH_MAX, 64, largest legal input map width; sizes the row accumulator buffer.
- HEIGHT_MAX, 64, largest legal input map height.
- ACC_WIDTH, DATA_WIDTH+6, accumulator width; holds the sum of 49 pixels.

Ports:
- ACLK, input, 1, clock; all logic on the rising edge.
- ARESET, input, 1, asynchronous active-high reset.
- cfg_start, input, 1, one-cycle start pulse; sampled only in IDLE.
- cfg_kernel, input, 3, K; legal range 1..KERNEL_MAX_SIZE.
- cfg_mode, input, 2, 0=max, 1=min, 2=avg; 3 is illegal.
- cfg_shift, input, 6, right-shift applied to the sum in avg mode.
- cfg_width, input, clog2(WIDTH_MAX+1), input columns W.
- cfg_height, input, clog2(HEIGHT_MAX+1), input rows H.
- busy, output, 1, high from an accepted start until done.
- done, output, 1, one-cycle pulse at completion.
- err, output, 1, one-cycle pulse when a start is rejected.
- in_data, input, DATA_WIDTH, pixel.
- in_valid, input, 1, pixel valid.
- in_ready, output, 1, pixel accepted when in_valid && in_ready.
- out_data, output, DATA_WIDTH, pooled result.
- out_valid, output, 1, result valid.
- out_ready, input, 1, result consumed when out_valid && out_ready.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Buffer contents are don't-care. Reset asserted mid-operation aborts immediately; no done pulse is issued.
- Config latch: config is latched when cfg_start is accepted. Output size is OW=floor(W/K), OH=floor(H/K).
- Start rejection: the start is rejected (err pulse next cycle, stay IDLE) if any of the following holds:
  - K==0 or K>KERNEL_MAX_SIZE;
  - cfg_mode==3;
  - W==0 or W>WIDTH_MAX;
  - H==0 or H>HEIGHT_MAX;
  - W<K or H<K.
- cfg_start in any state other than IDLE is ignored.
- States:
  - IDLE: on a legal start, go to RUN; busy=1 on the next cycle.
  - RUN: accept exactly W*H pixels. After the last pixel is accepted, go to FLUSH.
  - FLUSH: wait until out_valid==0 or the final result handshakes, then go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Counters:
  - col 0..W-1, row 0..H-1.
  - kc 0..K-1 (column within window), oc (output column); kc wraps and oc increments.
  - kr 0..K-1 (row within window), orow; both advance at end of row.
  - All column counters clear at end of row.
- Discarded pixels: pixels with oc>=OW (right remainder) or orow>=OH (bottom remainder) are accepted and discarded, with no buffer update.
- Accumulation, one row buffer entry per output column (acc[oc], ACC_WIDTH):
  - first pixel of window (kr==0 && kc==0): acc[oc] <= sign-extended pixel.
  - otherwise, max: acc <= max(acc, pixel); min: min; avg: acc + pixel.
  - All comparisons are signed.
- Result generation: on the last pixel of a window (kr==K-1 && kc==K-1), the combined value goes to the output register and out_valid=1 on the next cycle. Latency is 1 cycle from acceptance.
- avg result: (sum >>> cfg_shift), saturated to the signed DATA_WIDTH range.
- max/min result: low DATA_WIDTH bits of the combined value.
- Backpressure: in_ready = (state==RUN) && (!out_valid || out_ready). A pixel that completes a window and the handshake of the previous result may occur in the same cycle; the new result replaces the old with no gap.
- Output stability: out_data and out_valid hold stable while out_valid && !out_ready.
- Output order: row-major over the OW x OH results, OW*OH results total.
- K==1 is a pass-through: every pixel is emitted (avg mode still applies shift and saturation).

Test Plan:
- Reset, then start with K=2, mode=max, W=4, H=4, pixels 0..15 raster, out_ready=1 -> outputs 5,7,13,15; done pulse once; busy low afterwards.
- K=3, mode=avg, shift=0, W=7, H=6, all pixels=1 -> OW=2, OH=2; four outputs each 9; remainder column 6 discarded; exactly 42 pixels accepted.
- K=2, mode=min, W=2, H=2, pixels {-3,5,-8,2} -> single output -8.
- K=2, mode=avg, shift=0, DATA_WIDTH=8, four pixels 127 -> output saturates to 127. Repeat with four pixels -128 -> -128.
- K=2, mode=max, W=4, H=2, out_ready held low for 5 cycles after the first result -> in_ready drops; out_data stable; no pixel lost; second result correct after release.
- Illegal starts:
  - K=0 -> err pulse, busy stays 0.
  - K=8 -> err pulse, busy stays 0.
  - mode=3 -> err pulse, busy stays 0.
  - W=1 with K=2 -> err pulse, busy stays 0.
- Mid-run checks:
  - cfg_start pulsed mid-run -> ignored.
  - ARESET mid-run -> outputs 0 immediately; a fresh start afterwards works.
